// File: rtl/add_seq_pkg.sv
// Shared types and default sizing for the serial add/subtract sequencer.
package add_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int WIDTH_DEF   = 32;
    localparam int SLICE_W_DEF = 8;

    // Index width never collapses to zero bits, even for a single slice.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int NSLICE = WIDTH_DEF / SLICE_W_DEF;
    localparam int IDX_W  = idx_width(NSLICE);

endpackage

// File: rtl/slice_add8.sv
// Combinational SLICE_W-bit adder slice; every carry is a flat sum-of-products
// of generate/propagate terms rather than a ripple chain.
module slice_add8 #(
    parameter int SLICE_W = 8
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout
);

    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;
    logic [SLICE_W:0]   c;
    logic               carry;
    logic               prop;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        c     = '0;
        carry = 1'b0;
        prop  = 1'b0;
        c[0]  = cin;
        for (int i = 0; i < SLICE_W; i++) begin
            carry = g[i];
            prop  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                carry = carry | (prop & g[j]);
                prop  = prop & p[j];
            end
            c[i+1] = carry | (prop & cin);
        end
    end

    assign sum  = p ^ c[SLICE_W-1:0];
    assign cout = c[SLICE_W];

endmodule

// File: rtl/serial_add_ctrl.sv
// Multi-cycle add/subtract that walks one narrow lookahead slice across the
// operands, least significant slice first, with a registered inter-slice carry.
module serial_add_ctrl
    import add_seq_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int SLICE_W = SLICE_W_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             busy
);

    localparam int SLICES = WIDTH / SLICE_W;
    localparam int IDXW   = idx_width(SLICES);

    state_t             state;
    state_t             next_state;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   result_q;
    logic               carry_q;
    logic               carry_out_q;
    logic               overflow_q;
    logic [IDXW-1:0]    idx;
    logic [SLICE_W-1:0] slice_a;
    logic [SLICE_W-1:0] slice_b;
    logic [SLICE_W-1:0] slice_sum;
    logic               slice_cout;
    logic               is_last;

    assign slice_a = a_q[idx*SLICE_W +: SLICE_W];
    assign slice_b = b_q[idx*SLICE_W +: SLICE_W];
    assign is_last = (idx == IDXW'(SLICES - 1));

    slice_add8 #(
        .SLICE_W(SLICE_W)
    ) u_slice (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid)  next_state = RUN;
            RUN:     if (is_last)   next_state = DONE;
            DONE:    if (out_ready) next_state = IDLE;
            default:                next_state = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
    end

    // Subtraction is A + ~B + 1: B is inverted at capture and the +1 rides in as the first carry.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            idx         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= op_a;
                        b_q      <= sub ? ~op_b : op_b;
                        carry_q  <= sub;
                        idx      <= '0;
                        result_q <= '0;
                    end
                end
                RUN: begin
                    result_q[idx*SLICE_W +: SLICE_W] <= slice_sum;
                    carry_q <= slice_cout;
                    if (!is_last) begin
                        idx <= idx + 1'b1;
                    end else begin
                        carry_out_q <= slice_cout;
                        overflow_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                       (slice_sum[SLICE_W-1] != a_q[WIDTH-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed vector table, multi-cycle
// corner sequences, and randomized traffic against a signed/unsigned reference.
module tb_serial_add_ctrl;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        carry_out;
    logic        overflow;
    logic        busy;

    int checks = 0;
    int errors = 0;

    serial_add_ctrl #(
        .WIDTH   (32),
        .SLICE_W (8)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] res;
        logic        c;
        logic        v;
    } vec_t;

    vec_t vecs[7];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    // Reference: result modulo 2^32, carry from unsigned arithmetic, overflow from true signed range.
    function automatic logic [33:0] refModel(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint      sa;
        longint      sb;
        longint      sr;
        logic [31:0] r;
        logic        c;
        logic        v;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sr = s ? (sa - sb) : (sa + sb);
        v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        r  = s ? (a - b) : (a + b);
        c  = s ? (a >= b) : (((64'(a) + 64'(b)) >> 32) != 64'd0);
        return {v, c, r};
    endfunction

    // Called on a falling edge with the DUT idle; returns on a falling edge after the result handshake.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s,
                                 output logic [31:0] res, output logic c, output logic v, output int lat);
        checkOutput("in_ready_before_accept", 32'(in_ready), 32'd1);
        op_a      = a;
        op_b      = b;
        sub       = s;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        op_a     = $urandom;
        op_b     = $urandom;
        sub      = ~s;
        lat      = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        res       = result;
        c         = carry_out;
        v         = overflow;
        out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] res;
        logic        c;
        logic        v;
        int          lat;
        logic        saw_valid;
        logic [33:0] expv;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        logic        done;
        logic        hs;
        int          cyc;
        int          gap;

        vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0};
        vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
        vecs[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[5] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
        vecs[6] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};

        @(negedge clock);
        checkOutput("reset_in_ready",  32'(in_ready),  32'd1);
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_busy",      32'(busy),      32'd0);
        checkOutput("reset_result",    result,         32'd0);
        checkOutput("reset_carry",     32'(carry_out), 32'd0);
        checkOutput("reset_overflow",  32'(overflow),  32'd0);
        reset_n = 1'b1;
        @(negedge clock);
        checkOutput("post_reset_in_ready",  32'(in_ready),  32'd1);
        checkOutput("post_reset_out_valid", 32'(out_valid), 32'd0);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].s, res, c, v, lat);
            checkOutput($sformatf("vec%0d_result", i),   res,     vecs[i].res);
            checkOutput($sformatf("vec%0d_carry", i),    32'(c),  32'(vecs[i].c));
            checkOutput($sformatf("vec%0d_overflow", i), 32'(v),  32'(vecs[i].v));
            checkOutput($sformatf("vec%0d_latency", i),  32'(lat), 32'd4);
        end

        // Backpressure with a new request already waiting on the input side.
        op_a = 32'hAAAA_0000; op_b = 32'h0000_5555; sub = 1'b0;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        checkOutput("bp_latency", 32'(lat), 32'd4);
        op_a = 32'h0000_0001; op_b = 32'h0000_0002; sub = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checkOutput("bp_result_stable", result,          32'hAAAA_5555);
            checkOutput("bp_carry_stable",  32'(carry_out),  32'd0);
            checkOutput("bp_ovf_stable",    32'(overflow),   32'd0);
            checkOutput("bp_in_ready_low",  32'(in_ready),   32'd0);
            checkOutput("bp_out_valid",     32'(out_valid),  32'd1);
        end
        out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        out_ready = 1'b0;
        checkOutput("bp_idle_in_ready",  32'(in_ready),  32'd1);
        checkOutput("bp_idle_out_valid", 32'(out_valid), 32'd0);
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        checkOutput("bp_next_accepted", 32'(busy), 32'd1);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        checkOutput("bp_next_latency", 32'(lat), 32'd4);
        checkOutput("bp_next_result",  result,   32'h0000_0003);
        out_ready = 1'b1;
        @(posedge clock);
        @(negedge clock);
        out_ready = 1'b0;

        // Reset while the third slice is about to be processed.
        op_a = 32'h0101_0101; op_b = 32'h0101_0101; sub = 1'b0; in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        checkOutput("abort_result",    result,          32'd0);
        checkOutput("abort_busy",      32'(busy),       32'd0);
        checkOutput("abort_out_valid", 32'(out_valid),  32'd0);
        checkOutput("abort_in_ready",  32'(in_ready),   32'd1);
        checkOutput("abort_carry",     32'(carry_out),  32'd0);
        checkOutput("abort_overflow",  32'(overflow),   32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        saw_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (out_valid) saw_valid = 1'b1;
        end
        checkOutput("abort_no_out_valid", 32'(saw_valid), 32'd0);
        applyStimulus(32'h1234_5678, 32'h1111_1111, 1'b0, res, c, v, lat);
        checkOutput("after_abort_result",   res,      32'h2345_6789);
        checkOutput("after_abort_carry",    32'(c),   32'd0);
        checkOutput("after_abort_overflow", 32'(v),   32'd0);
        checkOutput("after_abort_latency",  32'(lat), 32'd4);

        // Randomized traffic with idle gaps and random consumer stalls.
        for (int n = 0; n < 100; n++) begin
            ra   = $urandom;
            rb   = $urandom;
            rs   = 1'($urandom_range(0, 1));
            expv = refModel(ra, rb, rs);
            gap  = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                op_a = $urandom;
                op_b = $urandom;
                @(negedge clock);
            end
            op_a = ra; op_b = rb; sub = rs; in_valid = 1'b1;
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clock);
            @(negedge clock);
            done = 1'b0;
            cyc  = 0;
            while (!done && cyc < 40) begin
                if (out_valid) begin
                    in_valid = 1'b0;
                    checkOutput("rnd_result",   result,         expv[31:0]);
                    checkOutput("rnd_carry",    32'(carry_out), 32'(expv[32]));
                    checkOutput("rnd_overflow", 32'(overflow),  32'(expv[33]));
                    out_ready = 1'($urandom_range(0, 1));
                end else begin
                    in_valid  = 1'($urandom_range(0, 1));
                    op_a      = $urandom;
                    op_b      = $urandom;
                    sub       = 1'($urandom_range(0, 1));
                    out_ready = 1'($urandom_range(0, 1));
                end
                hs = out_valid && out_ready;
                @(posedge clock);
                @(negedge clock);
                cyc++;
                if (hs) done = 1'b1;
            end
            in_valid  = 1'b0;
            out_ready = 1'b0;
            checkOutput("rnd_handshake", 32'(done), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
